// File: rtl/sprite_color_mapper.sv
// sprite_color_mapper: three-stage sprite hit test, ROM lookup and palette colour
// pipeline that overlays hardware sprites on a maze/background pixel stream.
module sprite_color_mapper #(
   parameter int          NUM_SPRITES = 4,
   parameter int          SPR_W       = 16,
   parameter int          SPR_H       = 16,
   parameter int          ANIM_DIV    = 8,
   parameter logic [23:0] WALL_RGB    = 24'h1F2BDB,
   parameter logic [23:0] BG_RGB      = 24'h000000,
   localparam int         XW          = $clog2(SPR_W),
   localparam int         YW          = $clog2(SPR_H),
   localparam int         IW          = $clog2(NUM_SPRITES),
   localparam int         AW          = IW + 4 + XW + YW
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       pixel_valid_in,
   input  logic [9:0]                 DrawX,
   input  logic [9:0]                 DrawY,
   input  logic                       maze_in,
   input  logic                       frame_start,
   input  logic [10*NUM_SPRITES-1:0]  sprite_x,
   input  logic [10*NUM_SPRITES-1:0]  sprite_y,
   input  logic [NUM_SPRITES-1:0]     sprite_en,
   input  logic [2*NUM_SPRITES-1:0]   sprite_dir,
   output logic [AW-1:0]              rom_addr,
   input  logic [3:0]                 rom_data,
   input  logic                       pal_we,
   input  logic [3:0]                 pal_addr,
   input  logic [23:0]                pal_data,
   output logic [7:0]                 VGA_R,
   output logic [7:0]                 VGA_G,
   output logic [7:0]                 VGA_B,
   output logic                       pixel_valid_out,
   output logic [3:0]                 hit_id
);
   localparam int DW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;

   logic [DW-1:0] div_q;
   logic [1:0]    anim_q;
   logic          wrap;
   logic [10:0]   x, y, sx, sy;
   logic          hit_d;
   logic [3:0]    id_d;
   logic [AW-1:0] addr_d;
   logic          v1_q, hit1_q, maze1_q;
   logic [3:0]    id1_q;
   logic          v2_q, opq2_q, maze2_q;
   logic [3:0]    idx2_q, id2_q;
   logic [23:0]   rgb_d;
   logic [3:0]    hid_d;
   logic [23:0]   pal_q [16];

   assign wrap = div_q == DW'(ANIM_DIV - 1);
   assign x    = {1'b0, DrawX};
   assign y    = {1'b0, DrawY};

   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         div_q  <= '0;
         anim_q <= '0;
      end else if (frame_start) begin
         div_q  <= wrap ? '0 : div_q + 1'b1;
         anim_q <= anim_q + {1'b0, wrap};
      end

   // Descending scan so the lowest-indexed hit sprite is the one left standing.
   always_comb begin
      hit_d  = 1'b0;
      id_d   = 4'hF;
      addr_d = '0;
      sx     = '0;
      sy     = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         sx = {1'b0, sprite_x[10*i +: 10]};
         sy = {1'b0, sprite_y[10*i +: 10]};
         if (sprite_en[i] && x >= sx && x < sx + 11'(SPR_W) && y >= sy && y < sy + 11'(SPR_H)) begin
            hit_d  = 1'b1;
            id_d   = 4'(i);
            addr_d = AW'(i) << (AW - IW) | AW'({sprite_dir[2*i +: 2], anim_q, YW'(y - sy), XW'(x - sx)});
         end
      end
   end

   always_comb begin
      rgb_d = !v2_q ? 24'h0 : opq2_q ? pal_q[idx2_q] : maze2_q ? WALL_RGB : BG_RGB;
      hid_d = (v2_q && opq2_q) ? id2_q : 4'hF;
   end

   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         v1_q            <= 1'b0;
         hit1_q          <= 1'b0;
         maze1_q         <= 1'b0;
         id1_q           <= 4'hF;
         rom_addr        <= '0;
         v2_q            <= 1'b0;
         opq2_q          <= 1'b0;
         maze2_q         <= 1'b0;
         idx2_q          <= '0;
         id2_q           <= 4'hF;
         {VGA_R, VGA_G, VGA_B} <= '0;
         pixel_valid_out <= 1'b0;
         hit_id          <= 4'hF;
      end else begin
         v1_q            <= pixel_valid_in;
         hit1_q          <= hit_d;
         maze1_q         <= maze_in;
         id1_q           <= id_d;
         rom_addr        <= addr_d;
         v2_q            <= v1_q;
         opq2_q          <= hit1_q && rom_data != 4'd0;
         maze2_q         <= maze1_q;
         idx2_q          <= rom_data;
         id2_q           <= id1_q;
         {VGA_R, VGA_G, VGA_B} <= rgb_d;
         pixel_valid_out <= v2_q;
         hit_id          <= hid_d;
      end

   always_ff @(posedge Clk or posedge Reset)
      if (Reset) begin
         for (int i = 0; i < 16; i++) pal_q[i] <= '0;
      end else if (pal_we) begin
         pal_q[pal_addr] <= pal_data;
      end
endmodule

// File: tb/tb_sprite_color_mapper.sv
// tb_sprite_color_mapper: directed checks of the sprite colour pipeline; the ROM
// model returns (dx + 2) mod 16, so dx = 14 reads as the transparent index.
module tb_sprite_color_mapper;
   logic        Clk = 1'b0, Reset = 1'b1;
   logic        pixel_valid_in = 1'b0, maze_in = 1'b0, frame_start = 1'b0;
   logic [9:0]  DrawX = '0, DrawY = '0;
   logic [39:0] sprite_x = '0, sprite_y = '0;
   logic [3:0]  sprite_en = '0;
   logic [7:0]  sprite_dir = '0;
   logic [13:0] rom_addr;
   logic [3:0]  rom_data;
   logic        pal_we = 1'b0;
   logic [3:0]  pal_addr = '0;
   logic [23:0] pal_data = '0;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        pixel_valid_out;
   logic [3:0]  hit_id;
   int          total = 0, bad = 0;

   sprite_color_mapper #(.ANIM_DIV(2)) dut (
      .Clk(Clk), .Reset(Reset), .pixel_valid_in(pixel_valid_in), .DrawX(DrawX), .DrawY(DrawY),
      .maze_in(maze_in), .frame_start(frame_start), .sprite_x(sprite_x), .sprite_y(sprite_y),
      .sprite_en(sprite_en), .sprite_dir(sprite_dir), .rom_addr(rom_addr), .rom_data(rom_data),
      .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data), .VGA_R(VGA_R), .VGA_G(VGA_G),
      .VGA_B(VGA_B), .pixel_valid_out(pixel_valid_out), .hit_id(hit_id));

   always #5 Clk = ~Clk;
   assign rom_data = rom_addr[3:0] + 4'd2;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic px(input int px_x, input int px_y, input logic m);
      DrawX = 10'(px_x);
      DrawY = 10'(px_y);
      maze_in = m;
      pixel_valid_in = 1'b1;
   endtask

   task automatic out(input string tag, input logic [23:0] rgb, input logic [3:0] id);
      chk({tag, "_pv"}, {31'd0, pixel_valid_out}, 32'd1);
      chk({tag, "_rgb"}, {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, rgb});
      chk({tag, "_id"}, {28'd0, hit_id}, {28'd0, id});
   endtask

   task automatic pal(input logic [3:0] a, input logic [23:0] d);
      pal_we = 1'b1;
      pal_addr = a;
      pal_data = d;
      tick();
      pal_we = 1'b0;
   endtask

   task automatic spr(input int i, input int sx, input int sy, input logic [1:0] dir);
      sprite_x[10*i +: 10] = 10'(sx);
      sprite_y[10*i +: 10] = 10'(sy);
      sprite_dir[2*i +: 2] = dir;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_pv", {31'd0, pixel_valid_out}, 32'd0);
      chk("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
      chk("rst_id", {28'd0, hit_id}, 32'hF);
      chk("rst_addr", {18'd0, rom_addr}, 32'd0);
      Reset = 1'b0;
      pal(4'd5, 24'hFFFF00);
      pal(4'd2, 24'h0000AA);
      pal(4'd3, 24'h00BB00);
      pal(4'd7, 24'h777777);
      pal(4'd12, 24'hCCCCCC);
      pal(4'd14, 24'hEEEEEE);
      pal(4'd11, 24'h0B0B0B);
      // single sprite, 3-cycle latency
      spr(0, 100, 50, 2'd0);
      sprite_en = 4'b0001;
      px(103, 52, 1'b0);
      tick();
      chk("single_addr", {18'd0, rom_addr}, 32'h0023);
      pixel_valid_in = 1'b0;
      tick();
      chk("single_early_pv", {31'd0, pixel_valid_out}, 32'd0);
      tick();
      out("single", 24'hFFFF00, 4'd0);
      // back-to-back stream including a wall pixel left of the sprite and one just below it
      px(100, 50, 1'b0); tick();
      px(101, 50, 1'b0); tick();
      px(99, 50, 1'b1);  tick();
      out("strm0", 24'h0000AA, 4'd0);
      px(100, 66, 1'b0); tick();
      out("strm1", 24'h00BB00, 4'd0);
      pixel_valid_in = 1'b0;
      tick();
      out("strm2_wall", 24'h1F2BDB, 4'hF);
      tick();
      out("strm3_below", 24'h000000, 4'hF);
      tick();
      chk("strm_idle_pv", {31'd0, pixel_valid_out}, 32'd0);
      chk("strm_idle_id", {28'd0, hit_id}, 32'hF);
      // overlapping sprites 0 and 2: priority and no transparency fall-through
      spr(0, 200, 200, 2'd0);
      spr(2, 208, 200, 2'd3);
      sprite_en = 4'b0101;
      px(205, 203, 1'b0); tick();
      chk("ovl_a_addr", {18'd0, rom_addr}, 32'h0035);
      px(210, 203, 1'b0); tick();
      chk("ovl_b_addr", {18'd0, rom_addr}, 32'h003A);
      px(220, 203, 1'b0); tick();
      chk("ovl_c_addr", {18'd0, rom_addr}, 32'h2C3C);
      out("ovl_a", 24'h777777, 4'd0);
      px(214, 203, 1'b1); tick();
      chk("ovl_d_addr", {18'd0, rom_addr}, 32'h003E);
      out("ovl_b_prio", 24'hCCCCCC, 4'd0);
      pixel_valid_in = 1'b0;
      tick();
      out("ovl_c_spr2", 24'hEEEEEE, 4'd2);
      tick();
      out("ovl_d_transp", 24'h1F2BDB, 4'hF);
      // right-edge clipping, no wrap
      spr(1, 630, 0, 2'd1);
      sprite_en = 4'b0010;
      px(639, 5, 1'b0); tick();
      chk("edge_hit_addr", {18'd0, rom_addr}, 32'h1459);
      px(0, 5, 1'b0); tick();
      chk("edge_wrap_addr", {18'd0, rom_addr}, 32'd0);
      pixel_valid_in = 1'b0;
      tick();
      out("edge_hit", 24'h0B0B0B, 4'd1);
      tick();
      out("edge_nowrap", 24'h000000, 4'hF);
      // palette write in the same cycle as the stage-3 read of that entry
      spr(0, 100, 50, 2'd0);
      sprite_en = 4'b0001;
      px(103, 52, 1'b0); tick();
      tick();
      pixel_valid_in = 1'b0;
      pal_we = 1'b1;
      pal_addr = 4'd5;
      pal_data = 24'h123456;
      tick();
      pal_we = 1'b0;
      out("pal_old", 24'hFFFF00, 4'd0);
      tick();
      out("pal_new", 24'h123456, 4'd0);
      // animation divider: each pulse samples the current frame before advancing
      for (int k = 0; k < 9; k++) begin
         frame_start = 1'b1;
         px(103, 52, 1'b0);
         tick();
         chk($sformatf("anim%0d", k), {30'd0, rom_addr[9:8]}, 32'((k / 2) % 4));
      end
      frame_start = 1'b0;
      pixel_valid_in = 1'b0;
      tick(); tick(); tick();
      // reset with three pixels in flight
      px(103, 52, 1'b0); tick(); tick(); tick();
      out("pre_rst", 24'h123456, 4'd0);
      #2 Reset = 1'b1;
      pixel_valid_in = 1'b0;
      #1;
      chk("rst_mid_pv", {31'd0, pixel_valid_out}, 32'd0);
      chk("rst_mid_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
      chk("rst_mid_id", {28'd0, hit_id}, 32'hF);
      tick(); tick();
      Reset = 1'b0;
      tick(); tick(); tick();
      chk("rst_post_pv", {31'd0, pixel_valid_out}, 32'd0);
      px(103, 52, 1'b0); tick();
      chk("rst_anim_addr", {18'd0, rom_addr}, 32'h0023);
      pixel_valid_in = 1'b0;
      tick();
      chk("rst_first_early", {31'd0, pixel_valid_out}, 32'd0);
      tick();
      out("rst_first_pal0", 24'h000000, 4'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
